// File: rtl/fwd_hazard_scoreboard.sv
// ============================================================================
//  Module      : fwd_hazard_scoreboard
//  Description : N-source / M-stage youngest-first operand bypass select plus a
//                per-register latency scoreboard raising the ID-stage stall.
//                Optional perf counters enabled by defining FWD_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_hazard_scoreboard #(
    parameter  int NUM_SRC    = 2,
    parameter  int NUM_STAGES = 2,
    parameter  int AW         = 5,
    parameter  int MAX_LAT    = 4,
    localparam int LW         = $clog2(MAX_LAT + 1),
    localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       id_valid,
    input  logic [NUM_SRC*AW-1:0]      id_rs,
    input  logic [NUM_SRC-1:0]         id_use,
    input  logic                       issue,
    input  logic                       flush,
    input  logic [AW-1:0]              issue_rd,
    input  logic                       issue_wr,
    input  logic [LW-1:0]              issue_lat,
    input  logic [NUM_SRC*AW-1:0]      ex_rs,
    input  logic [NUM_SRC-1:0]         ex_use,
    input  logic [NUM_STAGES*AW-1:0]   stg_rd,
    input  logic [NUM_STAGES-1:0]      stg_wr,
    input  logic [NUM_STAGES-1:0]      stg_rdy,
    output logic                       stall,
    output logic [NUM_SRC*SELW-1:0]    fwd_sel,
    output logic                       fwd_err,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                fwd_cnt
);

    localparam int            C_NREG    = 2 ** AW;
    localparam logic [LW-1:0] C_MAX_LAT = LW'(MAX_LAT);

    logic [LW-1:0]             w_cnt [C_NREG];
    logic [LW-1:0]             w_lat;
    logic                      w_stall_raw;
    logic                      w_stall;
    logic                      w_ie;
    logic [NUM_SRC*SELW-1:0]   w_fwd_sel;
    logic [NUM_SRC-1:0]        w_nrdy;
    logic                      w_fwd_err;

    assign w_lat = (issue_lat > C_MAX_LAT) ? C_MAX_LAT : issue_lat;
    assign w_ie  = issue & id_valid & ~w_stall & ~flush;

    assign w_cnt[0] = '0;

    // One down-counter per architectural register; x0 has none.
    genvar r;
    generate
        for (r = 1; r < C_NREG; r++) begin : g_cnt
            logic [LW-1:0] r_cnt;
            logic [LW-1:0] w_dec;
            logic [LW-1:0] w_nxt;

            always_comb begin
                w_dec = (r_cnt != '0) ? (r_cnt - LW'(1)) : '0;
                w_nxt = w_dec;
                if (w_ie && issue_wr && (issue_rd == AW'(r))) begin
                    w_nxt = (w_lat > w_dec) ? w_lat : w_dec;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_nxt;
                end
            end

            assign w_cnt[r] = r_cnt;
        end
    endgenerate

    always_comb begin
        w_stall_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_use[i] && (id_rs[i*AW +: AW] != '0) && (w_cnt[id_rs[i*AW +: AW]] != '0)) begin
                w_stall_raw = 1'b1;
            end
        end
    end

    assign w_stall = ~RST & id_valid & w_stall_raw;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        w_fwd_sel = '0;
        w_nrdy    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_use[i] && (ex_rs[i*AW +: AW] != '0)) begin
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    if (stg_wr[k] && (stg_rd[k*AW +: AW] == ex_rs[i*AW +: AW])) begin
                        w_fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                        w_nrdy[i]                 = ~stg_rdy[k];
                    end
                end
            end
        end
        w_fwd_err = |w_nrdy;
    end

    assign stall   = w_stall;
    assign fwd_sel = RST ? '0 : w_fwd_sel;
    assign fwd_err = ~RST & w_fwd_err;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic [31:0] w_fwd_num;

    always_comb begin
        w_fwd_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_sel[i*SELW +: SELW] != '0) begin
                w_fwd_num = w_fwd_num + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_fwd_cnt <= r_fwd_cnt + w_fwd_num;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed-vector bench for fwd_hazard_scoreboard (default parameters).
`default_nettype none

module tb_fwd_hazard_scoreboard;

`ifdef FWD_PERF_CNT_EN
    localparam logic [31:0] PERF = 32'd1;
`else
    localparam logic [31:0] PERF = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_use;
    logic        issue;
    logic        flush;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic [2:0]  issue_lat;
    logic [9:0]  ex_rs;
    logic [1:0]  ex_use;
    logic [9:0]  stg_rd;
    logic [1:0]  stg_wr;
    logic [1:0]  stg_rdy;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        fwd_err;
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;

    int n_vec = 0;
    int n_err = 0;

    fwd_hazard_scoreboard dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
        .issue(issue), .flush(flush), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .issue_lat(issue_lat), .ex_rs(ex_rs), .ex_use(ex_use), .stg_rd(stg_rd),
        .stg_wr(stg_wr), .stg_rdy(stg_rdy), .stall(stall), .fwd_sel(fwd_sel),
        .fwd_err(fwd_err), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        id_valid = 0; id_rs = '0; id_use = '0; issue = 0; flush = 0;
        issue_rd = '0; issue_wr = 0; issue_lat = '0; ex_rs = '0; ex_use = '0;
        stg_rd = '0; stg_wr = '0; stg_rdy = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] lat);
        id_valid = 1; issue = 1; issue_wr = 1; issue_rd = rd; issue_lat = lat;
    endtask

    task automatic test_reset;
        RST = 1;
        id_valid = 1; id_rs = {5'd3, 5'd4}; id_use = 2'b11;
        issue = 1; issue_wr = 1; issue_rd = 5'd4; issue_lat = 3'd4;
        ex_rs = {5'd3, 5'd4}; ex_use = 2'b11;
        stg_rd = {5'd3, 5'd4}; stg_wr = 2'b11; stg_rdy = 2'b00;
        tick(); tick();
        n_vec++;
        if ({stall, fwd_sel, fwd_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%b sel=%b err=%b, want all 0", stall, fwd_sel, fwd_err);
        end
        n_vec++;
        if ({stall_cnt, fwd_cnt} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", stall_cnt, fwd_cnt);
        end
        idle();
        RST = 0;
        tick();
    endtask

    task automatic test_alu_chain;
        idle(); do_issue(5'd5, 3'd0);
        tick();
        idle(); id_valid = 1; id_rs = {5'd0, 5'd5}; id_use = 2'b01;
        ex_rs = {5'd0, 5'd5}; ex_use = 2'b01;
        stg_rd = {5'd0, 5'd5}; stg_wr = 2'b01; stg_rdy = 2'b01;
        #1;
        n_vec++;
        if ({stall, fwd_sel, fwd_err} !== {1'b0, 4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL alu_chain: got stall=%b sel=%b err=%b, want 0 0001 0", stall, fwd_sel, fwd_err);
        end
        tick();
    endtask

    task automatic test_load_use;
        idle(); do_issue(5'd7, 3'd1);
        tick();
        // dependent is itself a write to x7; its issue must be ignored while stalled
        idle(); id_valid = 1; id_rs = {5'd0, 5'd7}; id_use = 2'b01;
        issue = 1; issue_wr = 1; issue_rd = 5'd7; issue_lat = 3'd1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_stall: got stall=%b, want 1", stall);
        end
        tick();
        issue_wr = 0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_release: got stall=%b, want 0", stall);
        end
        tick();
        idle(); ex_rs = {5'd0, 5'd7}; ex_use = 2'b01;
        stg_rd = {5'd7, 5'd0}; stg_wr = 2'b10; stg_rdy = 2'b11;
        #1;
        n_vec++;
        if ({fwd_sel, fwd_err} !== {4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL load_use_fwd_wb: got sel=%b err=%b, want 0010 0", fwd_sel, fwd_err);
        end
        tick();
    endtask

    task automatic test_priority;
        idle(); ex_rs = {5'd0, 5'd3}; ex_use = 2'b11;
        stg_rd = {5'd3, 5'd3}; stg_wr = 2'b11; stg_rdy = 2'b11;
        #1;
        n_vec++;
        if ({fwd_sel, fwd_err} !== {4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL prio_youngest: got sel=%b err=%b, want 0001 0", fwd_sel, fwd_err);
        end
        stg_rdy = 2'b10;
        #1;
        n_vec++;
        if ({fwd_sel, fwd_err} !== {4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL prio_err_young: got sel=%b err=%b, want 0001 1", fwd_sel, fwd_err);
        end
        stg_rdy = 2'b01;
        #1;
        n_vec++;
        if ({fwd_sel, fwd_err} !== {4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL prio_err_old_ignored: got sel=%b err=%b, want 0001 0", fwd_sel, fwd_err);
        end
        ex_rs = {5'd8, 5'd3}; stg_rd = {5'd8, 5'd3}; stg_rdy = 2'b11;
        #1;
        n_vec++;
        if (fwd_sel !== 4'b1001) begin
            n_err++;
            $display("FAIL prio_two_src: got sel=%b, want 1001", fwd_sel);
        end
        ex_use = 2'b01; stg_wr = 2'b10;
        #1;
        n_vec++;
        if (fwd_sel !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_no_match: got sel=%b, want 0000", fwd_sel);
        end
        ex_rs = '0; ex_use = 2'b11; stg_rd = '0; stg_wr = 2'b11;
        #1;
        n_vec++;
        if (fwd_sel !== 4'b0000) begin
            n_err++;
            $display("FAIL prio_x0_fwd: got sel=%b, want 0000", fwd_sel);
        end
        idle(); do_issue(5'd0, 3'd4);
        tick();
        idle(); id_valid = 1; id_rs = '0; id_use = 2'b11;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL prio_x0_stall: got stall=%b, want 0", stall);
        end
        tick();
    endtask

    task automatic test_waw;
        logic [3:0] exp_st;
        idle(); do_issue(5'd9, 3'd4);
        tick();
        idle(); do_issue(5'd9, 3'd1);
        tick();
        exp_st = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            idle(); id_valid = 1; id_rs = {5'd0, 5'd9}; id_use = 2'b01;
            #1;
            n_vec++;
            if (stall !== exp_st[c]) begin
                n_err++;
                $display("FAIL waw_stall_c%0d: got stall=%b, want %b", c, stall, exp_st[c]);
            end
            tick();
        end
        idle(); do_issue(5'd9, 3'd4); flush = 1;
        tick();
        idle(); id_valid = 1; id_rs = {5'd0, 5'd9}; id_use = 2'b01;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL waw_flush_issue: got stall=%b, want 0", stall);
        end
        tick();
    endtask

    task automatic test_flush_keep;
        idle(); do_issue(5'd10, 3'd2);
        tick();
        idle(); id_valid = 1; flush = 1;
        tick();
        idle(); id_valid = 0; id_rs = {5'd10, 5'd0}; id_use = 2'b10;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_invalid_id: got stall=%b, want 0", stall);
        end
        id_valid = 1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL flush_keeps_cnt: got stall=%b, want 1", stall);
        end
        tick();
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cnt_expire: got stall=%b, want 0", stall);
        end
        tick();
    endtask

    task automatic test_clamp;
        logic [5:0] exp_st;
        idle(); do_issue(5'd11, 3'd7);
        tick();
        exp_st = 6'b001111;
        for (int c = 0; c < 6; c++) begin
            idle(); id_valid = 1; id_rs = {5'd11, 5'd0}; id_use = 2'b10;
            #1;
            n_vec++;
            if (stall !== exp_st[c]) begin
                n_err++;
                $display("FAIL clamp_stall_c%0d: got stall=%b, want %b", c, stall, exp_st[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        idle(); do_issue(5'd4, 3'd4);
        tick();
        idle(); RST = 1; id_valid = 1; id_rs = {5'd0, 5'd4}; id_use = 2'b01;
        ex_rs = {5'd0, 5'd4}; ex_use = 2'b01; stg_rd = {5'd0, 5'd4}; stg_wr = 2'b01;
        #1;
        n_vec++;
        if ({stall, fwd_sel, fwd_err} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got stall=%b sel=%b err=%b, want 0", stall, fwd_sel, fwd_err);
        end
        tick();
        RST = 0; ex_use = '0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_dropped: got stall=%b, want 0", stall);
        end
        tick();
    endtask

    task automatic test_perf;
        idle(); RST = 1;
        tick();
        RST = 0; do_issue(5'd7, 3'd1);
        tick();
        // forwarding during the stall cycle must not be counted
        idle(); id_valid = 1; id_rs = {5'd0, 5'd7}; id_use = 2'b01;
        ex_rs = {5'd0, 5'd7}; ex_use = 2'b01; stg_rd = {5'd0, 5'd7}; stg_wr = 2'b01; stg_rdy = 2'b01;
        tick();
        n_vec++;
        if ({stall_cnt, fwd_cnt} !== {PERF, 32'd0}) begin
            n_err++;
            $display("FAIL perf_after_stall: got %0d/%0d, want %0d/0", stall_cnt, fwd_cnt, PERF);
        end
        idle(); id_valid = 1; id_rs = {5'd0, 5'd7}; id_use = 2'b01; issue = 1;
        tick();
        idle(); ex_rs = {5'd0, 5'd7}; ex_use = 2'b01;
        stg_rd = {5'd7, 5'd0}; stg_wr = 2'b10; stg_rdy = 2'b11;
        tick();
        idle();
        tick();
        n_vec++;
        if ({stall_cnt, fwd_cnt} !== {PERF, PERF}) begin
            n_err++;
            $display("FAIL perf_load_use: got %0d/%0d, want %0d/%0d", stall_cnt, fwd_cnt, PERF, PERF);
        end
    endtask

    initial begin
        idle();
        RST = 1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority();
        test_waw();
        test_flush_keep();
        test_clamp();
        test_reset_mid();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
